// File: rtl/gpio_hex_display.sv
// gpio_hex_display: turns the CPU gpio_out word into eight active-low
// 7-segment decimal digits using an iterative double-dabble converter.
// A new value is captured whenever it differs from the one last captured;
// the display and overflow flag update together once the conversion ends.
module gpio_hex_display #(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7,
   output logic        busy,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [7:0][6:0] HEX_RESET = BLANK_LEADING ?
      {{7{SEG_BLANK}}, SEG_ZERO} : {8{SEG_ZERO}};

   state_t          state_q, state_d;
   logic [31:0]     held_q, held_d;
   logic [31:0]     bin_q, bin_d;
   logic [39:0]     bcd_q, bcd_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic [7:0][6:0] hex_q, hex_d;

   logic [35:0]     bcdAdj;
   logic [7:0][6:0] segLit;
   logic            resultOvf;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    encode = 7'h40;
         4'd1:    encode = 7'h79;
         4'd2:    encode = 7'h24;
         4'd3:    encode = 7'h30;
         4'd4:    encode = 7'h19;
         4'd5:    encode = 7'h12;
         4'd6:    encode = 7'h02;
         4'd7:    encode = 7'h78;
         4'd8:    encode = 7'h00;
         4'd9:    encode = 7'h10;
         default: encode = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction on digits 0..8. Digit 9 never exceeds 4 while shifting
   // and its top bit falls off the end, so it needs no correction.
   always_comb begin
      bcdAdj = bcd_q[35:0];
      for (int i = 0; i < 9; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Segment patterns for the finished result, with leading zeros blanked
   // unless the value overflows eight digits or blanking is disabled.
   always_comb begin : displayLogic
      logic anyNonZero;
      anyNonZero = 1'b0;
      segLit     = {8{SEG_BLANK}};
      resultOvf  = |bcd_q[39:32];
      for (int k = 7; k >= 0; k--) begin
         anyNonZero = anyNonZero | (bcd_q[4*k +: 4] != 4'd0);
         if (anyNonZero || (k == 0) || resultOvf || !BLANK_LEADING) begin
            segLit[k] = encode(bcd_q[4*k +: 4]);
         end
      end
   end

   // Next-state logic: capture on change, 32 shift cycles, one display cycle.
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      hex_d   = hex_q;
      case (state_q)
         IDLE: begin
            if (value != held_q) begin
               held_d  = value;
               bin_d   = value;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_q[38:36], bcdAdj, bin_q[31]};
            bin_d = {bin_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
            end
         end
         DONE: begin
            hex_d   = segLit;
            ovf_d   = resultOvf;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; a synchronous reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         held_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         hex_q   <= HEX_RESET;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         hex_q   <= hex_d;
      end
   end

   assign hex0     = hex_q[0];
   assign hex1     = hex_q[1];
   assign hex2     = hex_q[2];
   assign hex3     = hex_q[3];
   assign hex4     = hex_q[4];
   assign hex5     = hex_q[5];
   assign hex6     = hex_q[6];
   assign hex7     = hex_q[7];
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Testbench for gpio_hex_display: table of known vectors, a few random
// values checked against a decimal model, and hand-written sequences for
// value changes during a conversion and reset in the middle of one.
module tb_gpio_hex_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic        busy;
   logic        overflow;

   typedef struct {
      logic [31:0]     value;
      logic [7:0][6:0] hex;
      logic            ovf;
   } vec_t;

   vec_t expQ[$];
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;

   gpio_hex_display #(.BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst(rst), .value(value),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
      .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
      .busy(busy), .overflow(overflow)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // Decimal reference model built on division rather than shifting.
   function automatic vec_t model(input logic [31:0] v);
      vec_t        r;
      logic [31:0] rem;
      logic [3:0]  d [8];
      int          top;
      r.value = v;
      r.ovf   = (v > 32'd99_999_999);
      rem     = v;
      top     = 0;
      for (int i = 0; i < 8; i++) begin
         d[i] = 4'(rem % 32'd10);
         rem  = rem / 32'd10;
         if (d[i] != 4'd0) top = i;
      end
      for (int i = 0; i < 8; i++) begin
         r.hex[i] = (r.ovf || i <= top) ? segOf(d[i]) : 7'h7F;
      end
      return r;
   endfunction

   function automatic logic [7:0][6:0] curHex();
      return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkReset(input string name);
      logic [7:0][6:0] h;
      h = curHex();
      checkValue({name, "_hex0"}, 32'(h[0]), 32'h40);
      for (int k = 1; k < 8; k++) begin
         checkValue($sformatf("%s_hex%0d", name, k), 32'(h[k]), 32'h7F);
      end
      checkValue({name, "_busy"}, 32'(busy), 32'd0);
      checkValue({name, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   // Pops the oldest expected result and compares it to the display.
   task automatic checkOutput();
      vec_t            e;
      logic [7:0][6:0] h;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got output with no expected entry");
         return;
      end
      e = expQ.pop_front();
      h = curHex();
      for (int k = 0; k < 8; k++) begin
         checkValue($sformatf("hex%0d(value=%0d)", k, e.value), 32'(h[k]), 32'(e.hex[k]));
      end
      checkValue($sformatf("overflow(value=%0d)", e.value), 32'(overflow), 32'(e.ovf));
   endtask

   // Drives one value from IDLE and follows the conversion to completion.
   task automatic applyStimulus(input vec_t e);
      logic [7:0][6:0] snap;
      int              n;
      value = e.value;
      expQ.push_back(e);
      step();
      checkValue("busyRise", 32'(busy), 32'd1);
      snap = curHex();
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
         if (n == 32) begin
            checkValue("hexStableWhileBusy", 32'(curHex() == snap), 32'd1);
         end
      end
      checkValue($sformatf("latency(value=%0d)", e.value), n, 32'd33);
      checkOutput();
   endtask

   initial begin
      int n;
      vecs[0] = '{32'd1234,        {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19}, 1'b0};
      vecs[1] = '{32'd99_999_999,  {8{7'h10}}, 1'b0};
      vecs[2] = '{32'd100_000_000, {8{7'h40}}, 1'b1};
      vecs[3] = '{32'hFFFF_FFFF,   {7'h10,7'h19,7'h10,7'h02,7'h78,7'h24,7'h10,7'h12}, 1'b1};
      vecs[4] = '{32'd10,          {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}, 1'b0};
      vecs[5] = '{32'd10_000_000,  {7'h79,{7{7'h40}}}, 1'b0};
      vecs[6] = '{32'd0,           {{7{7'h7F}},7'h40}, 1'b0};

      rst   = 1'b1;
      value = 32'd0;
      step();
      step();
      checkReset("reset");
      rst = 1'b0;
      repeat (3) step();
      checkValue("idleWithZero_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      for (int i = 0; i < 3; i++) begin
         applyStimulus(model($urandom));
         applyStimulus(model($urandom_range(1, 99_999)));
      end

      // Value changes while busy: 5 is shown, 7 is skipped, 8 follows.
      value = 32'd5;
      expQ.push_back(model(32'd5));
      step();
      checkValue("busyRise5", 32'(busy), 32'd1);
      repeat (10) step();
      value = 32'd7;
      repeat (10) step();
      value = 32'd8;
      repeat (13) step();
      checkValue("busyDrop5", 32'(busy), 32'd0);
      checkOutput();
      expQ.push_back(model(32'd8));
      step();
      checkValue("recapture8", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      checkValue("latency8", n, 32'd33);
      checkOutput();

      // Reset pulsed mid-conversion of 42, then a fresh conversion.
      value = 32'd42;
      step();
      checkValue("busyRise42", 32'(busy), 32'd1);
      repeat (14) step();
      rst = 1'b1;
      step();
      checkReset("midReset");
      rst = 1'b0;
      applyStimulus(model(32'd42));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
